// File: rtl/cp0_irq_pkg.sv
// Shared CP0 constants: register numbers, PRId default and IM/IP bit positions.
package cp0_irq_pkg;

  localparam logic [4:0]  Sel_COUNT   = 5'd9;
  localparam logic [4:0]  Sel_COMPARE = 5'd11;
  localparam logic [4:0]  Sel_SR      = 5'd12;
  localparam logic [4:0]  Sel_CAUSE   = 5'd13;
  localparam logic [4:0]  Sel_EPC     = 5'd14;
  localparam logic [4:0]  Sel_PRId    = 5'd15;

  localparam logic [31:0] PRId_Value  = 32'h0000_0C50;

  localparam int IM_LSB = 10;
  localparam int IP_LSB = 10;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match sets a sticky pending flag.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen_count_i,
  input  logic        wen_compare_i,
  input  logic [31:0] din_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pend_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  always_comb begin
    count_d   = wen_count_i ? din_i : count_q + 32'd1;
    compare_d = wen_compare_i ? din_i : compare_q;
    pend_d    = pend_q;
    // Rewriting Compare acknowledges the timer even if it matches on this edge.
    if (wen_compare_i) begin
      pend_d = 1'b0;
    end else if (count_q == compare_q) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/cp0_irq.sv
// CP0 coprocessor: SR, Cause, EPC, PRId and interrupt request for N_INT lines.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_irq
  import cp0_irq_pkg::*;
#(
  parameter int unsigned N_INT      = 6,
  parameter logic [5:0]  EDGE_MASK  = 6'b000000,
  parameter logic [31:0] PRID_VALUE = PRId_Value
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      PC,
  input  logic [31:0]      DIn,
  input  logic [N_INT-1:0] HWInt,
  input  logic [4:0]       Sel,
  input  logic             Wen,
  input  logic             EXLSet,
  input  logic             EXLClr,
  output logic             IntReq,
  output logic [29:0]      EPC,
  output logic [31:0]      DOut
);

  logic [N_INT-1:0] im_q, im_d;
  logic [N_INT-1:0] ip_q, ip_d;
  logic [N_INT-1:0] ip_eff;
  logic             exl_q, exl_d;
  logic             ie_q, ie_d;
  logic [29:0]      epc_q, epc_d;
  logic [31:0]      prid_q, prid_d;
  logic [31:0]      count_rd, compare_rd;
  logic             wen_sr, wen_cause, wen_epc, wen_prid;

  assign wen_sr    = Wen && (Sel == Sel_SR);
  assign wen_cause = Wen && (Sel == Sel_CAUSE);
  assign wen_epc   = Wen && (Sel == Sel_EPC);
  assign wen_prid  = Wen && (Sel == Sel_PRId);

  for (genvar i = 0; i < N_INT; i++) begin : g_line
    if (EDGE_MASK[i]) begin : g_edge
      logic prev_q;
      always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= HWInt[i];
      end
      // A fresh rising edge beats a same-cycle software clear.
      assign ip_d[i] = (HWInt[i] & ~prev_q) | (ip_q[i] & ~(wen_cause & ~DIn[IP_LSB+i]));
    end else begin : g_level
      assign ip_d[i] = HWInt[i];
    end
  end

  always_comb begin
    im_d   = im_q;
    ie_d   = ie_q;
    exl_d  = exl_q;
    epc_d  = epc_q;
    prid_d = prid_q;
    if (wen_sr) begin
      im_d  = DIn[IM_LSB +: N_INT];
      ie_d  = DIn[0];
      exl_d = DIn[1];
    end
    if (EXLSet)      exl_d = 1'b1;
    else if (EXLClr) exl_d = 1'b0;
    if (wen_epc) epc_d = DIn[31:2];
    if (EXLSet)  epc_d = PC;
    if (wen_prid) prid_d = DIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q   <= '0;
      ip_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b1;
      epc_q  <= 30'd0;
      prid_q <= PRID_VALUE;
    end else begin
      im_q   <= im_d;
      ip_q   <= ip_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      epc_q  <= epc_d;
      prid_q <= prid_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic wen_count, wen_compare, timer_pend;

  assign wen_count   = Wen && (Sel == Sel_COUNT);
  assign wen_compare = Wen && (Sel == Sel_COMPARE);

  cp0_timer u_timer (
    .clk           (clk),
    .rst           (rst),
    .wen_count_i   (wen_count),
    .wen_compare_i (wen_compare),
    .din_i         (DIn),
    .count_o       (count_rd),
    .compare_o     (compare_rd),
    .pend_o        (timer_pend)
  );

  // Timer shares the highest implemented line's IP/IM bit.
  always_comb begin
    ip_eff          = ip_q;
    ip_eff[N_INT-1] = ip_q[N_INT-1] | timer_pend;
  end
`else
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
  assign ip_eff     = ip_q;
`endif

  assign IntReq = (|(ip_eff & im_q)) & ie_q & ~exl_q;
  assign EPC    = epc_q;

  always_comb begin
    DOut = 32'd0;
    case (Sel)
      Sel_COUNT:   DOut = count_rd;
      Sel_COMPARE: DOut = compare_rd;
      Sel_SR: begin
        DOut[IM_LSB +: N_INT] = im_q;
        DOut[1]               = exl_q;
        DOut[0]               = ie_q;
      end
      Sel_CAUSE:   DOut[IP_LSB +: N_INT] = ip_eff;
      Sel_EPC:     DOut = {epc_q, 2'b00};
      Sel_PRId:    DOut = prid_q;
      default:     DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq.sv
// Self-checking bench for cp0_irq: directed scenarios plus randomized traffic
// checked against a register-level reference model.
module tb_cp0_irq;

  localparam int          N    = 6;
  localparam logic [5:0]  EDGE = 6'b000100;
  localparam logic [31:0] PRID = 32'h0000_0C50;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, Wen, EXLSet, EXLClr, IntReq;
  logic [29:0] PC, EPC;
  logic [31:0] DIn, DOut;
  logic [N-1:0] HWInt;
  logic [4:0]  Sel;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [N-1:0] m_im, m_ip, m_prev;
  logic         m_exl, m_ie, m_tpend;
  logic [29:0]  m_epc;
  logic [31:0]  m_prid, m_count, m_compare;

  always #5 clk = ~clk;

  cp0_irq #(.N_INT(N), .EDGE_MASK(EDGE), .PRID_VALUE(PRID)) dut (
    .clk(clk), .rst(rst), .PC(PC), .DIn(DIn), .HWInt(HWInt), .Sel(Sel),
    .Wen(Wen), .EXLSet(EXLSet), .EXLClr(EXLClr), .IntReq(IntReq),
    .EPC(EPC), .DOut(DOut)
  );

  task automatic model_step();
    logic match;
    if (rst) begin
      m_im = '0; m_ip = '0; m_prev = '0; m_exl = 1'b0; m_ie = 1'b1;
      m_epc = '0; m_prid = PRID; m_count = '0; m_compare = '1; m_tpend = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (EDGE[i]) begin
        if (HWInt[i] && !m_prev[i])                      m_ip[i] = 1'b1;
        else if (Wen && Sel == 5'd13 && !DIn[10+i])      m_ip[i] = 1'b0;
      end else begin
        m_ip[i] = HWInt[i];
      end
    end
    m_prev = HWInt;
    m_exl = EXLSet ? 1'b1 : EXLClr ? 1'b0 : (Wen && Sel == 5'd12) ? DIn[1] : m_exl;
    if (Wen && Sel == 5'd12) begin
      m_im = DIn[15:10];
      m_ie = DIn[0];
    end
    m_epc = EXLSet ? PC : (Wen && Sel == 5'd14) ? DIn[31:2] : m_epc;
    if (Wen && Sel == 5'd15) m_prid = DIn;
    if (TIMER) begin
      match = (m_count == m_compare);
      if (Wen && Sel == 5'd11) begin
        m_compare = DIn;
        m_tpend   = 1'b0;
      end else if (match) begin
        m_tpend = 1'b1;
      end
      m_count = (Wen && Sel == 5'd9) ? DIn : m_count + 32'd1;
    end
  endtask

  function automatic logic [N-1:0] m_ip_eff();
    logic [N-1:0] v;
    v = m_ip;
    if (TIMER) v[N-1] = v[N-1] | m_tpend;
    return v;
  endfunction

  function automatic logic m_intreq();
    return (|(m_ip_eff() & m_im)) & m_ie & ~m_exl;
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] s);
    case (s)
      5'd9:    return TIMER ? m_count : 32'd0;
      5'd11:   return TIMER ? m_compare : 32'd0;
      5'd12:   return {16'd0, m_im, 8'd0, m_exl, m_ie};
      5'd13:   return {16'd0, m_ip_eff(), 10'd0};
      5'd14:   return {m_epc, 2'b00};
      5'd15:   return m_prid;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    Wen = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    Sel = s; DIn = d; Wen = 1'b1;
    tick();
    Wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); HWInt = '0; PC = '0; DIn = '0; Sel = '0;
    tick(); tick();
    rst = 1'b0;
    Sel = 5'd12; #1;
    n_checks++; if (DOut !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_sr got %h want %h", DOut, 32'h1); end
    Sel = 5'd13; #1;
    n_checks++; if (DOut !== 32'h0) begin n_fail++; $display("FAIL reset_cause got %h want 0", DOut); end
    Sel = 5'd15; #1;
    n_checks++; if (DOut !== PRID) begin n_fail++; $display("FAIL reset_prid got %h want %h", DOut, PRID); end
    n_checks++; if (IntReq !== 1'b0) begin n_fail++; $display("FAIL reset_intreq got %b want 0", IntReq); end
    n_checks++; if (EPC !== 30'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", EPC); end
  endtask

  task automatic test_level_irq();
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; #1;
    n_checks++; if (IntReq !== 1'b0) begin n_fail++; $display("FAIL level_latency got %b want 0", IntReq); end
    tick();
    n_checks++; if (IntReq !== 1'b1) begin n_fail++; $display("FAIL level_raise got %b want 1", IntReq); end
    PC = 30'h0000_0C04; EXLSet = 1'b1;
    tick();
    EXLSet = 1'b0;
    n_checks++; if (EPC !== 30'h0000_0C04) begin n_fail++; $display("FAIL exlset_epc got %h want %h", EPC, 30'h0C04); end
    n_checks++; if (IntReq !== 1'b0) begin n_fail++; $display("FAIL exlset_drop got %b want 0", IntReq); end
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    n_checks++; if (IntReq !== 1'b1) begin n_fail++; $display("FAIL eret_reassert got %b want 1", IntReq); end
    HWInt = '0;
    tick();
  endtask

  task automatic test_edge_irq();
    HWInt = 6'b000100; tick();
    HWInt = '0; tick(); tick();
    Sel = 5'd13; #1;
    n_checks++; if (DOut !== 32'h0000_1000) begin n_fail++; $display("FAIL edge_sticky got %h want %h", DOut, 32'h1000); end
    mtc0(5'd13, 32'h0000_1000); #1;
    n_checks++; if (DOut !== 32'h0000_1000) begin n_fail++; $display("FAIL edge_write1 got %h want %h", DOut, 32'h1000); end
    mtc0(5'd13, 32'h0); #1;
    n_checks++; if (DOut !== 32'h0) begin n_fail++; $display("FAIL edge_clear got %h want 0", DOut); end
    HWInt = 6'b000100; Sel = 5'd13; DIn = 32'h0; Wen = 1'b1;
    tick();
    Wen = 1'b0; HWInt = '0; #1;
    n_checks++; if (DOut !== 32'h0000_1000) begin n_fail++; $display("FAIL edge_vs_clear got %h want %h", DOut, 32'h1000); end
    mtc0(5'd13, 32'h0);
  endtask

  task automatic test_exl_priority();
    PC = 30'h0000_0123; EXLSet = 1'b1; EXLClr = 1'b1;
    tick();
    idle(); Sel = 5'd12; #1;
    n_checks++; if (DOut[1] !== 1'b1) begin n_fail++; $display("FAIL set_vs_clr got %b want 1", DOut[1]); end
    Sel = 5'd12; DIn = 32'h0000_0403; Wen = 1'b1; EXLClr = 1'b1;
    tick();
    idle(); #1;
    n_checks++; if (DOut !== 32'h0000_0401) begin n_fail++; $display("FAIL sr_vs_clr got %h want %h", DOut, 32'h401); end
    PC = 30'h0000_0ABC; Sel = 5'd14; DIn = 32'h0000_0100; Wen = 1'b1; EXLSet = 1'b1;
    tick();
    idle();
    n_checks++; if (EPC !== 30'h0000_0ABC) begin n_fail++; $display("FAIL set_vs_epcwr got %h want %h", EPC, 30'hABC); end
    mtc0(5'd14, 32'h0000_0100);
    n_checks++; if (EPC !== 30'h0000_0040) begin n_fail++; $display("FAIL epc_write got %h want %h", EPC, 30'h40); end
    EXLClr = 1'b1; tick(); idle();
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    HWInt = '0;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (IntReq !== (k >= 6)) begin n_fail++; $display("FAIL timer_tick%0d got %b want %b", k, IntReq, k >= 6); end
    end
    mtc0(5'd11, 32'd20); #1;
    n_checks++; if (IntReq !== 1'b0) begin n_fail++; $display("FAIL timer_ack got %b want 0", IntReq); end
    n_checks++; if (DOut !== 32'd20) begin n_fail++; $display("FAIL compare_read got %h want %h", DOut, 32'd20); end
  endtask
`endif

  task automatic test_random();
    logic [4:0] sels [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};
    for (int c = 0; c < 400; c++) begin
      HWInt  = N'($urandom);
      Wen    = ($urandom_range(0, 3) == 0);
      Sel    = sels[$urandom_range(0, 7)];
      DIn    = $urandom;
      PC     = 30'($urandom);
      EXLSet = ($urandom_range(0, 7) == 0);
      EXLClr = ($urandom_range(0, 5) == 0);
      #1;
      n_checks++; if (DOut !== m_dout(Sel)) begin n_fail++; $display("FAIL rand_dout c=%0d sel=%0d got %h want %h", c, Sel, DOut, m_dout(Sel)); end
      n_checks++; if (IntReq !== m_intreq()) begin n_fail++; $display("FAIL rand_intreq c=%0d got %b want %b", c, IntReq, m_intreq()); end
      n_checks++; if (EPC !== m_epc) begin n_fail++; $display("FAIL rand_epc c=%0d got %h want %h", c, EPC, m_epc); end
      tick();
    end
    idle(); HWInt = '0;
    tick();
  endtask

  task automatic test_rst_mid_handler();
    mtc0(5'd15, 32'hDEAD_BEEF);
    mtc0(5'd12, 32'h0000_FC01);
    HWInt = 6'b000100; tick();
    HWInt = '0; EXLSet = 1'b1; tick(); idle();
    rst = 1'b1; EXLSet = 1'b1; Wen = 1'b1; Sel = 5'd12; DIn = 32'hFFFF_FFFF; HWInt = '1;
    tick();
    rst = 1'b0; idle(); HWInt = '0;
    Sel = 5'd12; #1;
    n_checks++; if (DOut !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_sr got %h want %h", DOut, 32'h1); end
    Sel = 5'd13; #1;
    n_checks++; if (DOut !== 32'h0) begin n_fail++; $display("FAIL rst_cause got %h want 0", DOut); end
    Sel = 5'd15; #1;
    n_checks++; if (DOut !== PRID) begin n_fail++; $display("FAIL rst_prid got %h want %h", DOut, PRID); end
    Sel = 5'd11; #1;
    n_checks++; if (DOut !== (TIMER ? 32'hFFFF_FFFF : 32'h0)) begin n_fail++; $display("FAIL rst_compare got %h", DOut); end
    n_checks++; if (EPC !== 30'h0) begin n_fail++; $display("FAIL rst_epc got %h want 0", EPC); end
    n_checks++; if (IntReq !== 1'b0) begin n_fail++; $display("FAIL rst_intreq got %b want 0", IntReq); end
  endtask

  initial begin
    test_reset();
    test_level_irq();
    test_edge_irq();
    test_exl_priority();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_random();
    test_rst_mid_handler();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
